multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  instruction condition field, Instr[31:28].
REQ-005 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch.
REQ-006 Funct  input  6  Instr[25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S or L.
REQ-007 ALUFlags  input  4  NZCV from the datapath ALU in the current cycle.
REQ-008 PCWrite, MemWrite, RegWrite, IRWrite  output  1 each  datapath write enables.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register.
REQ-010 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  output  2 each  datapath mux and ALU selects.

Function
REQ-011 The main FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH and UNKNOWN.
REQ-012 Transitions SHALL be: FETCH->DECODE; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN->FETCH.
REQ-013 From DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECR; Op=00 with Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->UNKNOWN.
REQ-014 From MEMADR: Funct[0]=1->MEMRD; Funct[0]=0->MEMWR.
REQ-015 Moore outputs (ALUSrcA/ALUSrcB/ResultSrc/AdrSrc; unlisted signals 0):
  - FETCH: 01/10/10/0, IRWrite=1, NextPC=1.
  - DECODE: 01/10/10.
  - MEMADR: 00/01, ALUOp=0.
  - MEMRD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: 00/00, ALUOp=1.
  - EXECI: 00/01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: 10/01/10, Branch=1.
  - UNKNOWN: all 0.
REQ-016 ALUControl SHALL be 00 (ADD) when ALUOp=0; when ALUOp=1, Funct[4:1]=0100->00, 0010->01 (SUB), 0000->10 (AND), 1100->11 (ORR), any other cmd->00.
REQ-017 FlagW[1] SHALL equal ALUOp&Funct[0]; FlagW[0] SHALL equal ALUOp&Funct[0]&(cmd is ADD or SUB).
REQ-018 ImmSrc SHALL equal Op; RegSrc[0] SHALL equal (Op==10); RegSrc[1] SHALL equal (Op==01).
REQ-019 CondEx SHALL decode Cond against the stored flags N,Z,C,V:
  - EQ/NE, CS/CC, MI/PL, VS/VC: standard single-flag tests.
  - HI = C&~Z, LS = its inverse.
  - GE = (N==V), LT = its inverse.
  - GT = ~Z&(N==V), LE = its inverse.
  - AL (1110) = 1; 1111 = 0.
REQ-020 Flags N,Z SHALL load ALUFlags[3:2] when FlagW[1]&CondEx; flags C,V SHALL load ALUFlags[1:0] when FlagW[0]&CondEx.
REQ-021 CondExD SHALL register CondEx every cycle.
REQ-022 RegWrite SHALL be RegW&CondExD; MemWrite SHALL be MemW&CondExD; PCWrite SHALL be NextPC|(Branch&CondExD).
REQ-023 Instruction latency SHALL be fixed: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined (Op=11) 3; it SHALL be independent of condition outcome.
REQ-024 A failed condition SHALL suppress RegWrite, MemWrite, branch PCWrite and flag updates but not the state sequence.
REQ-025 An instruction whose condition reads flags SHALL see flags written by the preceding instruction.

Reset
REQ-026 While reset=1 at a rising edge: state<=FETCH, NZCV<=0000, CondExD<=0.
REQ-027 Reset asserted mid-instruction SHALL abandon it; no write enable other than FETCH's PCWrite/IRWrite SHALL assert in the following cycle.
REQ-028 Output values during and immediately after reset SHALL be the FETCH outputs: IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0.

Structure
REQ-029 A shared package SHALL hold the state encoding (4-bit enum), the ALUControl codes and the condition-code constants.
REQ-030 Condition logic (flag register, CondEx, CondExD) SHALL be a sub-module named cond_logic; the FSM and decoders SHALL live in multicycle_ctrl.

Verification
REQ-031 ADD, Cond=1110, S=1, ALUFlags=0100 in EXECR -> states F,D,ER,AW; RegWrite=1 in AW; Z=1 afterwards.
REQ-032 BEQ issued after REQ-031 -> states F,D,BR; PCWrite=1 in BR. BNE in the same flag state -> PCWrite=0 in BR.
REQ-033 LDR (Op=01, Funct[0]=1) -> states F,D,MA,MR,MW; AdrSrc=1 in MR; RegWrite=1 only in MW.
REQ-034 STR (Funct[0]=0) -> MemWrite=1 exactly one cycle, in MWR; 4-cycle instruction.
REQ-035 SUBS with Cond=0000 while Z=0 -> no RegWrite and NZCV unchanged; the next instruction still fetches on cycle 5.
REQ-036 Reset asserted in MEMRD -> next state FETCH, NZCV=0000, no RegWrite; Op=11 -> D->UNKNOWN->FETCH with all enables 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle controller
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/multicycle_ctrl_cond.sv
// rtl/multicycle_ctrl_cond.sv - NZCV flag register and condition evaluation
module cond_logic
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_w,
    output logic       o_cond_ex_d
);

    logic [3:0] r_flags;
    logic       r_cond_ex_d;
    logic       w_cond_ex;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign o_cond_ex_d = r_cond_ex_d;

    // Evaluate the instruction condition against the currently stored flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~(w_c & ~w_z);
            COND_GE: w_cond_ex = (w_n == w_v);
            COND_LT: w_cond_ex = (w_n != w_v);
            COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ex = ~(~w_z & (w_n == w_v));
            COND_AL: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Flag halves update only when requested and the condition passes; CondEx is delayed one cycle for the write-back states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags     <= 4'b0000;
            r_cond_ex_d <= 1'b0;
        end else begin
            if (i_flag_w[1] && w_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_w[0] && w_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
            r_cond_ex_d <= w_cond_ex;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle ARM-style controller: main FSM, ALU and instruction decoders
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    state_t     r_state;
    state_t     w_next;
    logic       w_next_pc, w_reg_w, w_mem_w, w_branch, w_alu_op;
    logic [1:0] w_flag_w;
    logic       w_cond_ex_d;
    logic [3:0] w_cmd;

    assign w_cmd = Funct[4:1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state and Moore control outputs
    always_comb begin
        w_next    = r_state;
        w_next_pc = 1'b0;
        w_reg_w   = 1'b0;
        w_mem_w   = 1'b0;
        w_branch  = 1'b0;
        w_alu_op  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_next = S_DECODE;
                IRWrite = 1'b1; w_next_pc = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                case (Op)
                    OP_MEM:  w_next = S_MEMADR;
                    OP_DP:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   w_next = S_BRANCH;
                    default: w_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                w_next = Funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                w_next = S_FETCH;
                ResultSrc = 2'b01; w_reg_w = 1'b1;
            end
            S_MEMWR: begin
                w_next = S_FETCH;
                AdrSrc = 1'b1; w_mem_w = 1'b1;
            end
            S_EXECR: begin
                w_next = S_ALUWB;
                w_alu_op = 1'b1;
            end
            S_EXECI: begin
                w_next = S_ALUWB;
                ALUSrcB = 2'b01; w_alu_op = 1'b1;
            end
            S_ALUWB: begin
                w_next = S_FETCH;
                w_reg_w = 1'b1;
            end
            S_BRANCH: begin
                w_next = S_FETCH;
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // ALU decoder: operation select and which flag halves the instruction may update
    always_comb begin
        ALUControl = ALU_ADD;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (w_cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
            w_flag_w[1] = Funct[0];
            w_flag_w[0] = Funct[0] & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB));
        end
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};

    cond_logic u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (Cond),
        .i_alu_flags (ALUFlags),
        .i_flag_w    (w_flag_w),
        .o_cond_ex_d (w_cond_ex_d)
    );

    assign RegWrite = w_reg_w & w_cond_ex_d;
    assign MemWrite = w_mem_w & w_cond_ex_d;
    assign PCWrite  = w_next_pc | (w_branch & w_cond_ex_d);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    int total = 0;
    int bad   = 0;
    logic [3:0] m_flags;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !(c && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        if (cmd == 4'b0100) return 2'b00;
        if (cmd == 4'b0010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int instr_len(input logic [1:0] op, input logic [5:0] funct);
        if (op == 2'b01) return funct[0] ? 5 : 4;
        if (op == 2'b00) return 4;
        return 3;
    endfunction

    // expected {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,RegSrc}
    function automatic logic [16:0] exp_out(input logic [1:0] op, input logic [5:0] funct,
                                            input int c, input logic ok);
        logic pcw, memw, regw, irw, adr;
        logic [1:0] sa, sb, rs, al;
        {pcw, memw, regw, irw, adr} = 5'b0;
        {sa, sb, rs, al} = 8'b0;
        if (c == 0) begin
            pcw = 1; irw = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10;
        end else if (c == 1) begin
            sa = 2'b01; sb = 2'b10; rs = 2'b10;
        end else if (op == 2'b01) begin
            if (c == 2) sb = 2'b01;
            if (c == 3) begin adr = 1; memw = !funct[0] && ok; end
            if (c == 4) begin rs = 2'b01; regw = ok; end
        end else if (op == 2'b00) begin
            if (c == 2) begin sb = funct[5] ? 2'b01 : 2'b00; al = alu_of(funct[4:1]); end
            if (c == 3) regw = ok;
        end else if (op == 2'b10) begin
            sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = ok;
        end
        return {pcw, memw, regw, irw, adr, sa, sb, rs, al, op, (op == 2'b01), (op == 2'b10)};
    endfunction

    // one instruction starting in its fetch cycle; af<0 means random ALUFlags; abort_at>=0 resets in that cycle
    task automatic run_instr(input string name, input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] funct, input int af, input int abort_at);
        logic ok;
        int len;
        ok  = cond_holds(cond, m_flags);
        len = instr_len(op, funct);
        Cond = cond; Op = op; Funct = funct;
        for (int c = 0; c < len; c++) begin
            ALUFlags = (af < 0) ? 4'($urandom_range(0, 15)) : 4'(af);
            @(negedge clk);
            check($sformatf("%s_c%0d", name, c),
                  {15'b0, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ALUControl, ImmSrc, RegSrc},
                  {15'b0, exp_out(op, funct, c, ok)});
            if (op == 2'b00 && c == 2 && funct[0] && ok) begin
                m_flags[3:2] = ALUFlags[3:2];
                if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) m_flags[1:0] = ALUFlags[1:0];
            end
            if (c == abort_at) reset = 1'b1;
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                reset   = 1'b0;
                m_flags = 4'b0000;
                return;
            end
        end
    endtask

    initial begin
        logic [3:0] rc;
        logic [1:0] ro;
        logic [5:0] rf;
        reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'b0; ALUFlags = 4'b0;
        m_flags = 4'b0000;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("rst_outputs", {27'b0, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc}, {27'b0, 5'b10010});
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr("adds_z",  4'hE, 2'b00, 6'b001001, 4, -1);
        run_instr("beq_t",   4'h0, 2'b10, 6'b000000, -1, -1);
        run_instr("bne_nt",  4'h1, 2'b10, 6'b000000, -1, -1);
        run_instr("ldr",     4'hE, 2'b01, 6'b011001, -1, -1);
        run_instr("str",     4'hE, 2'b01, 6'b011000, -1, -1);
        run_instr("adds_nz", 4'hE, 2'b00, 6'b001001, 0, -1);
        run_instr("subs_nx", 4'h0, 2'b00, 6'b000101, 15, -1);
        run_instr("beq_nt",  4'h0, 2'b10, 6'b000000, -1, -1);
        run_instr("bcc_t",   4'h3, 2'b10, 6'b000000, -1, -1);
        run_instr("adds_set",4'hE, 2'b00, 6'b001001, 15, -1);
        run_instr("ldr_abrt",4'hE, 2'b01, 6'b011001, -1, 3);
        run_instr("beq_rst", 4'h0, 2'b10, 6'b000000, -1, -1);
        run_instr("bpl_rst", 4'h5, 2'b10, 6'b000000, -1, -1);
        run_instr("undef",   4'hE, 2'b11, 6'b111111, -1, -1);
        run_instr("orri_nv", 4'hF, 2'b00, 6'b111001, -1, -1);

        for (int i = 0; i < 400; i++) begin
            rc = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom_range(0, 63));
            run_instr($sformatf("rnd%0d", i), rc, ro, rf, -1,
                      ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 2)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
